// File: rtl/seq_pattern_gen_if.sv
// Bus bundle for seq_pattern_gen: request/pattern inputs and serial stream outputs.
// The repeat_cnt member exists only when SEQ_GEN_REPEAT_EN is defined.
interface seq_pattern_gen_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
`ifdef SEQ_GEN_REPEAT_EN
    parameter int REP_W   = 4,
`endif
    parameter int GAP_W   = 4
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [GAP_W-1:0]   gap;
`ifdef SEQ_GEN_REPEAT_EN
    logic [REP_W-1:0]   repeat_cnt;
`endif
    logic               out;
    logic               out_valid;
    logic               busy;
    logic               done;

`ifdef SEQ_GEN_REPEAT_EN
    modport master (
        output start, pattern, len, gap, repeat_cnt,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, gap, repeat_cnt,
        output out, out_valid, busy, done
    );
`else
    modport master (
        output start, pattern, len, gap,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, gap,
        output out, out_valid, busy, done
    );
`endif
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: latches a pattern on start and shifts it out MSB-first.
// Define SEQ_GEN_REPEAT_EN to enable repeated copies separated by a programmable idle gap.
module seq_pattern_gen #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
`ifdef SEQ_GEN_REPEAT_EN
    parameter int REP_W   = 4,
`endif
    parameter int GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_idx_q, bit_idx_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [MAX_LEN-1:0] shifted;
    logic               start_ok;

`ifdef SEQ_GEN_REPEAT_EN
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]   rep_left_q, rep_left_d;
`else
    logic [GAP_W-1:0]   unused_gap;

    assign unused_gap = bus.gap;
`endif

    // A start is also refused while done is showing, so the done cycle is never overlapped.
    assign start_ok = bus.start && !done_q && (bus.len != '0) && (bus.len <= MAX_LEN_L);
    assign shifted  = pat_q >> bit_idx_q;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        bit_idx_d   = bit_idx_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        rep_left_d  = rep_left_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pat_d     = bus.pattern;
                    len_d     = bus.len;
                    bit_idx_d = bus.len - LEN_ONE;
`ifdef SEQ_GEN_REPEAT_EN
                    gap_d      = bus.gap;
                    rep_left_d = bus.repeat_cnt;
`endif
                    state_d   = SEND;
                end
            end
            SEND: begin
                out_d       = shifted[0];
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - LEN_ONE;
                end else begin
`ifdef SEQ_GEN_REPEAT_EN
                    // Another copy follows: reload the index now so a zero gap has no bubble.
                    if (rep_left_q != '0) begin
                        rep_left_d = rep_left_q - REP_ONE;
                        bit_idx_d  = len_q - LEN_ONE;
                        if (gap_q != '0) begin
                            gap_cnt_d = gap_q;
                            state_d   = GAP;
                        end else begin
                            state_d   = SEND;
                        end
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            GAP: begin
`ifdef SEQ_GEN_REPEAT_EN
                busy_d    = 1'b1;
                gap_cnt_d = gap_cnt_q - GAP_ONE;
                if (gap_cnt_q == GAP_ONE) begin
                    state_d = SEND;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            bit_idx_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            rep_left_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            bit_idx_q   <= bit_idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SEQ_GEN_REPEAT_EN
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            rep_left_q  <= rep_left_d;
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: a per-cycle stream model built from the
// pattern/len/repeat/gap rules is compared against {out_valid, out, busy, done}.
module tb_seq_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [3:0] got;
    logic [3:0] exp_q[$];

    seq_pattern_gen_if bus ();

    seq_pattern_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected {out_valid, out, busy, done} per cycle, starting the cycle after the accepting edge.
    function automatic void build_model(input logic [7:0] p, input int l, input int reps, input int g);
        exp_q.delete();
        exp_q.push_back(4'b0000);
        for (int c = 0; c <= reps; c++) begin
            for (int k = l - 1; k >= 0; k--) exp_q.push_back({1'b1, p[k], 1'b1, 1'b0});
            if (c < reps) for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endfunction

    task automatic issue_start(input logic [7:0] p, input int l, input int reps, input int g);
        bus.pattern = p;
        bus.len     = 4'(l);
        bus.gap     = 4'(g);
`ifdef SEQ_GEN_REPEAT_EN
        bus.repeat_cnt = 4'(reps);
`else
        if (reps != 0) $display("[TB] note: repeat request dropped, feature not built");
`endif
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.pattern = 8'hA5;
        bus.len = 4'd3;
        bus.gap = 4'd0;
`ifdef SEQ_GEN_REPEAT_EN
        bus.repeat_cnt = 4'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            tests_run++;
            if (got !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b expected 0000", i, got);
            end
        end
        bus.start = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            tests_run++;
            if (got !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL reset_release cycle %0d: got %b expected 0000", i, got);
            end
        end
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int done_cnt = 0;
        build_model(8'b010, 3, 0, 0);
        issue_start(8'b010, 3, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL basic cycle %0d: got %b expected %b", i, got, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (busy_cnt != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL basic_counts: busy %0d done %0d, expected busy 3 done 1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] hist = 3'b000;
        build_model(8'b101, 3, 0, 0);
        issue_start(8'b101, 3, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            if (bus.out_valid) hist = {hist[1:0], bus.out};
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", i, got, exp_q[i]);
            end
            if (i == exp_q.size() - 2) begin
                tests_run++;
                if (hist !== 3'b101) begin
                    tests_failed++;
                    $display("[TB] FAIL detector_101: saw %b expected 101", hist);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignored_starts();
        int done_cnt = 0;
        bus.len = 4'd0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.len = 4'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            tests_run++;
            if (got !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL bad_len_ignored cycle %0d: got %b expected 0000", i, got);
            end
            @(posedge clk); #1;
        end
        build_model(8'b11001, 5, 0, 0);
        issue_start(8'b11001, 5, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            done_cnt += int'(bus.done);
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL busy_start_ignored cycle %0d: got %b expected %b", i, got, exp_q[i]);
            end
            bus.start = (i == 2 || i == exp_q.size() - 1);
            bus.pattern = 8'hFF;
            bus.len = 4'd4;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            done_cnt += int'(bus.done);
            tests_run++;
            if (got !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL done_start_ignored cycle %0d: got %b expected 0000", i, got);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got %0d pulses expected 1", done_cnt);
        end
    endtask

`ifdef SEQ_GEN_REPEAT_EN
    task automatic test_repeat();
        int busy_cnt = 0;
        build_model(8'b10, 2, 2, 1);
        issue_start(8'b10, 2, 2, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            busy_cnt += int'(bus.busy);
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL repeat cycle %0d: got %b expected %b", i, got, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (busy_cnt != 3 * 2 + 2 * 1) begin
            tests_failed++;
            $display("[TB] FAIL repeat_busy: got %0d cycles expected 8", busy_cnt);
        end
    endtask
`endif

    task automatic test_reset_mid();
        build_model(8'b1011_0110, 8, 0, 0);
        issue_start(8'b1011_0110, 8, 0, 0);
        for (int i = 0; i < 3; i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL pre_reset cycle %0d: got %b expected %b", i, got, exp_q[i]);
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        #2 rst = 1'b0;
        #1;
        got = {bus.out_valid, bus.out, bus.busy, bus.done};
        tests_run++;
        if (got !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %b expected 0000", got);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            tests_run++;
            if (got !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL reset_no_done cycle %0d: got %b expected 0000", i, got);
            end
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        issue_start(8'b1011_0110, 8, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = {bus.out_valid, bus.out, bus.busy, bus.done};
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL post_reset cycle %0d: got %b expected %b", i, got, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [7:0] p;
        int l, reps, g;
        for (int n = 0; n < 30; n++) begin
            p = 8'($urandom);
            l = $urandom_range(1, 8);
            g = $urandom_range(0, 3);
`ifdef SEQ_GEN_REPEAT_EN
            reps = $urandom_range(0, 3);
            build_model(p, l, reps, g);
`else
            reps = 0;
            build_model(p, l, 0, 0);
`endif
            issue_start(p, l, reps, g);
            for (int i = 0; i < exp_q.size(); i++) begin
                got = {bus.out_valid, bus.out, bus.busy, bus.done};
                tests_run++;
                if (got !== exp_q[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL random run %0d cycle %0d: got %b expected %b", n, i, got, exp_q[i]);
                end
                bus.start   = 1'($urandom_range(0, 1));
                bus.pattern = 8'($urandom);
                bus.len     = 4'($urandom_range(0, 15));
                bus.gap     = 4'($urandom_range(0, 15));
`ifdef SEQ_GEN_REPEAT_EN
                bus.repeat_cnt = 4'($urandom_range(0, 15));
`endif
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored_starts();
`ifdef SEQ_GEN_REPEAT_EN
        test_repeat();
`endif
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
